// File: rtl/madd_approx_seq_if.sv
// Operand/result handshake bundle for the sequential approximate multiply-add.
interface madd_approx_seq_if #(
  parameter int W = 6
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           approx_en;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           busy;

  modport master (
    output in_valid, a, b, c, approx_en, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, c, approx_en, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/madd_approx_seq.sv
// Radix-2 shift-add multiply-add (a*b + c) with optional column truncation.
//
// state  | meaning
// IDLE   | waiting for an operand set, in_ready high
// MUL    | one partial product per cycle, W cycles
// DONE   | result presented, waiting for out_ready
module madd_approx_seq #(
  parameter int W     = 6,
  parameter int TRUNC = 4
) (
  input logic              clk,
  input logic              rst_n,
  madd_approx_seq_if.slave bus
);

  if (W < 2 || W > 16) begin : g_bad_w
    $error("madd_approx_seq: W must be in 2..16");
  end
  if (TRUNC < 0 || TRUNC > 2*W-1) begin : g_bad_trunc
    $error("madd_approx_seq: TRUNC must be in 0..2W-1");
  end

  localparam int CW = $clog2(W);
  localparam logic [63:0]    LOW_MASK64 = (64'd1 << TRUNC) - 64'd1;
  localparam logic [2*W-1:0] LOW_MASK   = LOW_MASK64[2*W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic           approx_q;
  logic [2*W-1:0] acc, acc_nxt, res_q, pp;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_m;
  logic           accept, last_step;

  assign accept    = (state == S_IDLE) && bus.in_valid;
  assign last_step = (cnt == CW'(W-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.in_valid)  state_nxt = S_MUL;
      S_MUL:  if (last_step)     state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state == S_MUL) || (state == S_DONE);
  end

  // Current partial product; approximate mode drops bits landing below column TRUNC.
  always_comb begin
    a_m = a_q;
    if (approx_q) begin
      for (int j = 0; j < W; j++) begin
        if (int'(cnt) + j < TRUNC) a_m[j] = 1'b0;
      end
    end
    pp      = {{W{1'b0}}, a_m} << cnt;
    acc_nxt = b_q[cnt] ? acc + pp : acc;
  end

  // Operand latch, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        approx_q <= bus.approx_en;
        acc      <= {{W{1'b0}}, bus.c};
        cnt      <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_nxt;
        cnt <= last_step ? '0 : cnt + 1'b1;
        if (last_step) res_q <= approx_q ? (acc_nxt & ~LOW_MASK) : acc_nxt;
      end
    end
  end

  assign bus.result = res_q;

endmodule

// File: tb/tb_madd_approx_seq.sv
// Randomised and directed bench for madd_approx_seq against a column-sum model.
module tb_madd_approx_seq;
  localparam int W     = 6;
  localparam int TRUNC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [2*W-1:0] last_result = '0;
  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  bit             seen = 0;
  bit             post_hs = 0;

  madd_approx_seq_if #(.W(W)) bus ();

  madd_approx_seq #(.W(W), .TRUNC(TRUNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sum of every a_j*b_i*2^(i+j) column, dropping columns below TRUNC when approximate.
  function automatic logic [2*W-1:0] model(input int av, input int bv, input int cv, input bit ap);
    longint s = cv;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (((bv >> i) & 1) && ((av >> j) & 1) && (!ap || i + j >= TRUNC))
          s += longint'(1) << (i + j);
    if (ap) s = s & ~((longint'(1) << TRUNC) - 1);
    return s[2*W-1:0];
  endfunction

  // Compare process: reset values, handshake rules, latency and result on every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_result", bus.result, 0);
      exp_q.delete();
      acc_q.delete();
      seen = 0;
      post_hs = 0;
    end else begin
      if (post_hs) chk("ready_after_handshake", bus.in_ready, 1);
      post_hs = 0;
      chk("busy", bus.busy, !bus.in_ready);
      if (bus.out_valid) begin
        chk("ready_in_done", bus.in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("result", bus.result, exp_q[0]);
          if (!seen) chk("latency", cyc - acc_q[0], W + 1);
          seen = 1;
          if (bus.out_ready) begin
            last_result = bus.result;
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 0;
            post_hs = 1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.c, bus.approx_en));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.c         = W'($urandom);
    bus.approx_en = ~bus.approx_en;
  endtask

  task automatic do_op(input int av, input int bv, input int cv, input bit ap, input int hold);
    bit ok = 0;
    bus.a = W'(av); bus.b = W'(bv); bus.c = W'(cv); bus.approx_en = ap;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    wait_accept();
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1;
    end
    if (!ok) chk("result_timeout", 0, 1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.c = 0;
    bus.approx_en = 0; bus.out_ready = 0;

    chk("model_exact_max", model(63, 63, 63, 0), 4032);
    chk("model_approx_max", model(63, 63, 63, 1), 3968);
    chk("model_approx_small", model(5, 3, 2, 1), 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(63, 63, 63, 0, 0); chk("exact_max", last_result, 4032);
    do_op(63, 63, 63, 1, 0); chk("approx_max", last_result, 3968);
    do_op(5, 3, 2, 1, 0);    chk("approx_small", last_result, 0);
    do_op(5, 3, 2, 0, 0);    chk("exact_small", last_result, 17);
    do_op(10, 12, 7, 0, 5);  chk("backpressure", last_result, 127);
    do_op(0, 0, 0, 1, 0);    chk("zero", last_result, 0);

    bus.a = 6'd9; bus.b = 6'd9; bus.c = 6'd9; bus.approx_en = 0;
    bus.in_valid = 1'b1;
    wait_accept();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    chk("async_rst_result", bus.result, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(1, 1, 0, 0, 0); chk("after_reset", last_result, 1);

    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.c         = W'($urandom);
      bus.approx_en = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
